// File: rtl/tff_toggle_arb_if.sv
// Two-requester command bus for the shared T flip-flop bank.
// Each requester offers a toggle mask and a repeat count.
interface tff_toggle_arb_if #(
   parameter int unsigned WIDTH = 8
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_mask;
   logic [3:0]       req0_rep;
   logic             req0_ready;
   logic             req1_valid;
   logic [WIDTH-1:0] req1_mask;
   logic [3:0]       req1_rep;
   logic             req1_ready;

   modport master (
      output req0_valid, req0_mask, req0_rep,
      output req1_valid, req1_mask, req1_rep,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_mask, req0_rep,
      input  req1_valid, req1_mask, req1_rep,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/tff_toggle_arb.sv
// Shared T flip-flop bank arbitrated round-robin between two requesters.
// Each accepted command toggles q by its mask rep+1 times, one toggle per cycle.
module tff_toggle_arb #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   tff_toggle_arb_if.slave  bus,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             busy,
   output logic             grant_id,
   output logic             done
);
   typedef enum logic {IDLE, APPLY} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] mask_r;
   logic [3:0]       cnt_r;
   logic             rr;
   logic             ready0, ready1;
   logic             accept;

   // Readies are gated by rstn so both read low during reset.
   always_comb begin
      ready0 = 1'b0;
      ready1 = 1'b0;
      if (rstn && (state == IDLE) && !clr) begin
         if (bus.req0_valid && bus.req1_valid) begin
            ready0 = ~rr;
            ready1 = rr;
         end else begin
            ready0 = bus.req0_valid;
            ready1 = bus.req1_valid;
         end
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign accept         = ready0 | ready1;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = APPLY;
         APPLY:   if (clr || (cnt_r == 4'd0)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         q        <= '0;
         mask_r   <= '0;
         cnt_r    <= '0;
         rr       <= 1'b0;
         grant_id <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         if (clr) begin
            q <= '0;
         end else if (state == APPLY) begin
            q <= q ^ mask_r;
         end
         if (accept) begin
            mask_r   <= ready1 ? bus.req1_mask : bus.req0_mask;
            cnt_r    <= ready1 ? bus.req1_rep  : bus.req0_rep;
            grant_id <= ready1;
            rr       <= ~ready1;
         end
         // done is raised on the same edge that commits the final toggle.
         if ((state == APPLY) && !clr) begin
            if (cnt_r == 4'd0) begin
               done <= 1'b1;
            end else begin
               cnt_r <= cnt_r - 4'd1;
            end
         end
      end
   end

   assign qbar = ~q;
   assign busy = (state == APPLY);
endmodule

// File: doc/tff_toggle_arb.md
TFF_TOGGLE_ARB -- requirements
Module: tff_toggle_arb

Interface
REQ-001 Parameter: WIDTH, default 8, number of T flip-flops in the shared toggle bank.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester command valid.
REQ-005 req0_mask / req1_mask  input  WIDTH each  per-bit toggle enable (T inputs).
REQ-006 req0_rep / req1_rep  input  4 each  repeat count; command applies mask rep+1 times.
REQ-007 req0_ready / req1_ready  output  1 each  command accepted when valid and ready are both high at a rising edge.
REQ-008 clr  input  1  synchronous clear of the bank; highest priority.
REQ-009 q  output  WIDTH  flip-flop bank state, registered.
REQ-010 qbar  output  WIDTH  bitwise inverse of q, combinational.
REQ-011 busy  output  1  high while a command is executing (state APPLY).
REQ-012 grant_id  output  1  requester index of the command currently or last executed.
REQ-013 done  output  1  one-cycle pulse after the final toggle of a command.

Function
REQ-014 FSM states: IDLE, APPLY; no other states.
REQ-015 IDLE: at most one ready high; ready goes to the requester with valid high; if both valid, ready goes to the one selected by the round-robin pointer rr (0 -> req0, 1 -> req1).
REQ-016 Ready depends combinationally on valid and rr in IDLE only; both readies low in APPLY and while clr is high.
REQ-017 On acceptance: latch mask into mask_r, rep into cnt_r, winner into grant_id; rr set to the non-winner; go to APPLY.
REQ-018 APPLY each cycle: q <= q ^ mask_r; if cnt_r == 0 go to IDLE and pulse done next cycle, else cnt_r <= cnt_r - 1.
REQ-019 Command latency: first toggle visible on q one cycle after acceptance; last toggle rep+1 cycles after acceptance; done high in the same cycle the last toggle becomes visible.
REQ-020 Minimum spacing: next acceptance no earlier than the cycle after APPLY exits (throughput one command per rep+2 cycles).
REQ-021 mask_r == 0: command still accepted, occupies rep+1 APPLY cycles, q unchanged, done pulses.
REQ-022 Toggle parity: net effect of a command is q ^ mask when rep is even, q unchanged when rep is odd.
REQ-023 clr high at a rising edge: q <= 0; in APPLY, the command aborts, FSM -> IDLE, no done pulse; rr unchanged; in IDLE, no acceptance that cycle.
REQ-024 Single requester valid: granted regardless of rr; rr still moves to the non-winner.
REQ-025 Requester dropping valid before acceptance: no effect on state or rr.
REQ-026 Inputs mask/rep sampled only at acceptance; later changes ignored.

Reset
REQ-027 rstn low: immediately q = 0, qbar = all ones, state IDLE, cnt_r = 0, mask_r = 0, rr = 0, grant_id = 0, busy = 0, done = 0, both readies low.
REQ-028 rstn low mid-APPLY: command lost, no done; after release the block starts in IDLE with rr = 0.
REQ-029 First rising edge after rstn release may accept a command.

Verification
REQ-030 Reset then req0 mask=0x0F rep=0 -> accepted in 1 cycle; next cycle q=0x0F, qbar=0xF0, done=1, busy then 0.
REQ-031 Both valid from reset, req0 mask=0x01 rep=0, req1 mask=0x80 rep=0, held -> req0 granted first, req1 second; final q=0x81; grant_id sequence 0,1.
REQ-032 req1 mask=0xFF rep=3 from q=0x00 -> q alternates 0xFF,0x00,0xFF,0x00 over 4 cycles; done with final q=0x00; ready low throughout.
REQ-033 req0 mask=0x3C rep=15, clr pulsed on 3rd APPLY cycle -> q=0x00 next cycle, FSM IDLE, no done, new command acceptable next cycle.
REQ-034 rstn asserted mid-APPLY (req1 rep=7) asynchronously between edges -> q=0x00, busy=0 immediately; after release req0 and req1 both valid -> req0 granted.
REQ-035 req0 mask=0x00 rep=2 -> three busy cycles, q unchanged, done pulses once.
